// File: rtl/xedgcol_sequencer_pkg.sv
// Shared Xedgcol definitions: ECOL opcode, edge-count width and sequencer state encodings.
package xedgcol_sequencer_pkg;

  localparam logic [6:0] XEDGCOL_OPCODE_ECOL = 7'b0001011;
  localparam int XEDGCOL_COUNT_WIDTH = 5;
  localparam int XEDGCOL_HITS_WIDTH  = XEDGCOL_COUNT_WIDTH + 1;

  // 2'd3 is unused and decodes back to IDLE
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WB   = 2'd2
  } state_t;

endpackage

// File: rtl/xedgcol_sequencer.sv
// ECOL multi-cycle sequencer: stalls decode, walks 1-32 edge words through the
// collision unit with a req/ack handshake and retires the hit count in one WB cycle.
//
// state | meaning
// IDLE  | waiting for ECOL in decode; stall follows ecol_detect
// REQ   | requesting edge word idx from the collision unit
// WB    | single retire cycle, hit count written to rs1
module xedgcol_sequencer
  import xedgcol_sequencer_pkg::*;
#(
  parameter int N          = 32,
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           instr_valid,
  input  logic [6:0]                     opcode,
  input  logic [XEDGCOL_COUNT_WIDTH-1:0] count,
  output logic                           stall,
  output logic                           controlOverride,
  output logic [N-1:0]                   alu_offset,
  output logic                           col_req,
  input  logic                           col_ack,
  input  logic                           col_hit,
  output logic                           reg_we,
  output logic [N-1:0]                   result,
  output logic                           busy
);

  state_t                          state;
  logic [XEDGCOL_COUNT_WIDTH-1:0]  idx;
  logic [XEDGCOL_COUNT_WIDTH-1:0]  last;
  logic [XEDGCOL_HITS_WIDTH-1:0]   hits;
  logic                            ecol_detect;
  logic                            walk_done;

  assign ecol_detect = instr_valid && (opcode == XEDGCOL_OPCODE_ECOL) && (state == ST_IDLE);
  // exit at idx == last means idx never needs to wrap
  assign walk_done   = (idx == last) || (EARLY_EXIT && col_hit);
  assign busy        = (state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      idx   <= '0;
      last  <= '0;
      hits  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ecol_detect) begin
            last  <= count;
            idx   <= '0;
            hits  <= '0;
            state <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (col_ack) begin
            hits <= hits + XEDGCOL_HITS_WIDTH'(col_hit);
            if (walk_done) begin
              state <= ST_WB;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        ST_WB:   state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    stall           = 1'b0;
    controlOverride = 1'b0;
    col_req         = 1'b0;
    alu_offset      = '0;
    reg_we          = 1'b0;
    result          = '0;
    case (state)
      ST_IDLE: stall = ecol_detect;
      ST_REQ: begin
        stall           = 1'b1;
        controlOverride = 1'b1;
        col_req         = 1'b1;
        alu_offset      = N'({idx, 2'b00});
      end
      ST_WB: begin
        controlOverride = 1'b1;
        reg_we          = 1'b1;
        result          = N'(hits);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_xedgcol_sequencer.sv
// Scoreboard bench for xedgcol_sequencer: instance 0 with EARLY_EXIT=0, instance 1 with EARLY_EXIT=1.
module tb_xedgcol_sequencer;
  import xedgcol_sequencer_pkg::*;

  typedef struct {
    logic [31:0] offset;
    int          hold;
  } req_t;

  typedef struct {
    logic [31:0] res;
    int          latency;
    bit          b2b;
  } wb_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  opcode = '0;
  logic [4:0]  count = '0;
  logic        instr_valid [2];
  logic        stall [2];
  logic        control_override [2];
  logic [31:0] alu_offset [2];
  logic        col_req [2];
  logic        col_ack [2];
  logic        col_hit [2];
  logic        reg_we [2];
  logic [31:0] result [2];
  logic        busy [2];

  logic [31:0] hit_mask [2];
  int          wait_idx [2];
  int          wait_cnt [2];
  bit          spurious [2];
  bit          mon_en = 1'b0;

  req_t req_q [2][$];
  wb_t  wb_q  [2][$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    int  waited;
    int  hold;
    int  stall_cnt;
    int  detect_cyc;
    int  last_wb;
    req_t er;
    wb_t  ew;

    xedgcol_sequencer #(.N(32), .EARLY_EXIT(g == 1)) u_dut (
      .clk             (clk),
      .rst             (rst),
      .instr_valid     (instr_valid[g]),
      .opcode          (opcode),
      .count           (count),
      .stall           (stall[g]),
      .controlOverride (control_override[g]),
      .alu_offset      (alu_offset[g]),
      .col_req         (col_req[g]),
      .col_ack         (col_ack[g]),
      .col_hit         (col_hit[g]),
      .reg_we          (reg_we[g]),
      .result          (result[g]),
      .busy            (busy[g])
    );

    // collision unit model: optional ack withholding on one word, hits from a mask
    always @(posedge clk) begin
      #1;
      if (rst) begin
        col_ack[g] = 1'b0;
        col_hit[g] = 1'b0;
        waited     = 0;
      end else if (col_req[g]) begin
        if (alu_offset[g] == 32'(wait_idx[g] * 4) && waited < wait_cnt[g]) begin
          col_ack[g] = 1'b0;
          col_hit[g] = 1'b0;
          waited++;
        end else begin
          col_ack[g] = 1'b1;
          col_hit[g] = hit_mask[g][alu_offset[g][6:2]];
        end
      end else begin
        waited     = 0;
        col_ack[g] = spurious[g];
        col_hit[g] = spurious[g];
      end
    end

    // monitor: pops expectations whenever a request is accepted or a result retires
    always @(negedge clk) begin
      if (rst || !mon_en) begin
        hold      = 0;
        stall_cnt = 0;
      end else begin
        if (stall[g] && !busy[g]) begin
          detect_cyc = cyc;
          stall_cnt  = 0;
        end
        if (stall[g]) stall_cnt++;
        if (col_req[g]) begin
          hold++;
          if (col_ack[g]) begin
            if (req_q[g].size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_req inst=%0d actual offset=%0d required no request", g, alu_offset[g]);
            end else begin
              er = req_q[g].pop_front();
              chk($sformatf("req_offset%0d", g), alu_offset[g], er.offset);
              chk($sformatf("req_hold%0d", g), 32'(hold), 32'(er.hold));
              chk($sformatf("req_override%0d", g), 32'(control_override[g]), 32'd1);
            end
            hold = 0;
          end
        end else begin
          hold = 0;
        end
        if (reg_we[g]) begin
          if (wb_q[g].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_wb inst=%0d actual result=%0d required no write", g, result[g]);
          end else begin
            ew = wb_q[g].pop_front();
            chk($sformatf("wb_result%0d", g), result[g], ew.res);
            chk($sformatf("wb_latency%0d", g), 32'(cyc - detect_cyc + 1), 32'(ew.latency));
            chk($sformatf("wb_stall_cycles%0d", g), 32'(stall_cnt), 32'(ew.latency - 1));
            chk($sformatf("wb_stall_low%0d", g), 32'(stall[g]), 32'd0);
            chk($sformatf("wb_override%0d", g), 32'(control_override[g]), 32'd1);
            if (ew.b2b) chk($sformatf("b2b_gap%0d", g), 32'(detect_cyc - last_wb), 32'd1);
          end
          last_wb = cyc;
        end
      end
    end
  end

  task automatic push_req(input int g, input int off, input int hold);
    req_t r;
    r.offset = 32'(off);
    r.hold   = hold;
    req_q[g].push_back(r);
  endtask

  task automatic push_wb(input int g, input int res, input int lat, input bit b2b);
    wb_t w;
    w.res     = 32'(res);
    w.latency = lat;
    w.b2b     = b2b;
    wb_q[g].push_back(w);
  endtask

  task automatic wait_wb(input int g);
    bit seen = 1'b0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clk);
      if (reg_we[g]) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL wb_timeout inst=%0d actual no reg_we required reg_we within 200 cycles", g);
    end
    @(posedge clk);
  endtask

  task automatic run_walk(input int g, input int cnt);
    @(posedge clk);
    #2;
    instr_valid[g] = 1'b1;
    opcode         = XEDGCOL_OPCODE_ECOL;
    count          = 5'(cnt);
    @(posedge clk);
    #2;
    instr_valid[g] = 1'b0;
    count          = 5'd17;
    wait_wb(g);
  endtask

  initial begin
    bit found;
    for (int g = 0; g < 2; g++) begin
      instr_valid[g] = 1'b0;
      hit_mask[g]    = '0;
      wait_idx[g]    = 0;
      wait_cnt[g]    = 0;
      spurious[g]    = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy[0]), 32'd0);
    chk("rst_col_req", 32'(col_req[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // async reset in the middle of a walk, at idx 3
    @(posedge clk);
    #2;
    instr_valid[0] = 1'b1;
    opcode         = XEDGCOL_OPCODE_ECOL;
    count          = 5'd5;
    @(posedge clk);
    #2;
    instr_valid[0] = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      @(negedge clk);
      if (alu_offset[0] == 32'd12) found = 1'b1;
    end
    chk("rst_reach_idx3", 32'(found), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_col_req", 32'(col_req[0]), 32'd0);
    chk("rst_mid_stall", 32'(stall[0]), 32'd0);
    chk("rst_mid_busy", 32'(busy[0]), 32'd0);
    chk("rst_mid_offset", alu_offset[0], 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_idle", 32'(busy[0]), 32'd0);
    chk("post_rst_stall", 32'(stall[0]), 32'd0);
    mon_en = 1'b1;

    // single word, hit on idx 0
    hit_mask[0] = 32'h1;
    push_req(0, 0, 1);
    push_wb(0, 1, 3, 1'b0);
    run_walk(0, 0);

    // full walk, hits on idx 0, 5 and 31
    hit_mask[0] = 32'h8000_0021;
    for (int i = 0; i < 32; i++) push_req(0, 4 * i, 1);
    push_wb(0, 3, 34, 1'b0);
    run_walk(0, 31);

    // backpressure: ack withheld 4 cycles on idx 1
    hit_mask[0] = 32'h4;
    wait_idx[0] = 1;
    wait_cnt[0] = 4;
    push_req(0, 0, 1);
    push_req(0, 4, 5);
    push_req(0, 8, 1);
    push_wb(0, 1, 9, 1'b0);
    run_walk(0, 2);
    wait_cnt[0] = 0;

    // early exit on idx 2 versus full eight-word walk
    hit_mask[1] = 32'h4;
    for (int i = 0; i < 3; i++) push_req(1, 4 * i, 1);
    push_wb(1, 1, 5, 1'b0);
    run_walk(1, 7);
    hit_mask[0] = 32'h4;
    for (int i = 0; i < 8; i++) push_req(0, 4 * i, 1);
    push_wb(0, 1, 10, 1'b0);
    run_walk(0, 7);

    // back-to-back ECOL with spurious idle acks, then a non-ECOL instruction
    hit_mask[0] = 32'h6;
    spurious[0] = 1'b1;
    push_req(0, 0, 1);
    push_req(0, 4, 1);
    push_wb(0, 1, 4, 1'b0);
    push_req(0, 0, 1);
    push_req(0, 4, 1);
    push_req(0, 8, 1);
    push_wb(0, 2, 5, 1'b1);
    @(posedge clk);
    #2;
    instr_valid[0] = 1'b1;
    opcode         = XEDGCOL_OPCODE_ECOL;
    count          = 5'd1;
    @(posedge clk);
    #2;
    count = 5'd2;
    wait_wb(0);
    @(posedge clk);
    #2;
    opcode = 7'h33;
    wait_wb(0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("non_ecol_stall", 32'(stall[0]), 32'd0);
      chk("non_ecol_busy", 32'(busy[0]), 32'd0);
    end
    instr_valid[0] = 1'b0;
    spurious[0]    = 1'b0;
    repeat (3) @(posedge clk);

    for (int g = 0; g < 2; g++) begin
      chk($sformatf("req_q_drain%0d", g), 32'(req_q[g].size()), 32'd0);
      chk($sformatf("wb_q_drain%0d", g), 32'(wb_q[g].size()), 32'd0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
